seg_scan_ctrl: RTL

- Time-multiplexes NUM_DIGITS 3-bit display codes onto one shared 7-segment encoder (code in, segments out) and drives per-digit enables.
- Sits between the multiplier result/status logic, which supplies the codes, and the encoder plus board digit drivers.
- Double-buffers loaded codes so a frame never shows a mix of old and new digits.
- Inserts a blanking guard at every digit change to suppress ghosting.

---
 rtl/seg_pkg.sv | 18 +
 rtl/seg_slot_timer.sv | 45 ++++
 rtl/seg_scan_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the segment scan controller: code width, named codes and scan states.
package seg_pkg;

    localparam int unsigned CODE_W = 3;

    localparam logic [CODE_W-1:0] CODE_0   = 3'b000;
    localparam logic [CODE_W-1:0] CODE_1   = 3'b001;
    localparam logic [CODE_W-1:0] CODE_2   = 3'b010;
    localparam logic [CODE_W-1:0] CODE_3   = 3'b011;
    localparam logic [CODE_W-1:0] CODE_ERR = 3'b100;

    typedef enum logic [1:0] {
        StIdle,
        StBlank,
        StShow
    } scan_state_e;

endpackage

// File: rtl/seg_slot_timer.sv
// Per-slot down-counter: loads TICK_DIV-1 at slot start and strobes the end of blanking and of the slot.
module seg_slot_timer #(
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic load_i,
    output logic blank_end_o,
    output logic slot_end_o,
    output logic slot_end_next_o
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax   = CntW'(TICK_DIV - 1);
    // Count value seen in the last blanking cycle of a slot.
    localparam logic [CntW-1:0] BlankEnd = CntW'(TICK_DIV - BLANK_CYC);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CntMax;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign blank_end_o     = (cnt_q == BlankEnd);
    assign slot_end_o      = (cnt_q == '0);
    assign slot_end_next_o = (cnt_d == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexes double-buffered digit codes onto one shared encoder with a blanking guard per slot.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned CODE_W     = seg_pkg::CODE_W,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned BLANK_CYC  = 2
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         enable_i,
    input  logic                         load_valid_i,
    input  logic [NUM_DIGITS*CODE_W-1:0] load_data_i,
    output logic                         load_ready_o,
    output logic [CODE_W-1:0]            code_out_o,
    output logic [NUM_DIGITS-1:0]        digit_en_o,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o,
    output logic                         frame_done_o
);
    import seg_pkg::*;

    localparam int unsigned IdxW = $clog2(NUM_DIGITS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);
    localparam scan_state_e FirstState = (BLANK_CYC == 0) ? StShow : StBlank;

    scan_state_e state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [NUM_DIGITS-1:0][CODE_W-1:0] active_q, active_d, shadow_q, shadow_d;
    logic pending_q, pending_d, ready_q, frame_q, frame_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic accept, transfer, tmr_load, tmr_clear;
    logic blank_end, slot_end, slot_end_next;

    seg_slot_timer #(
        .TICK_DIV  (TICK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .clear_i         (tmr_clear),
        .load_i          (tmr_load),
        .blank_end_o     (blank_end),
        .slot_end_o      (slot_end),
        .slot_end_next_o (slot_end_next)
    );

    always_comb begin
        accept    = load_valid_i && ready_q;
        // Swap buffers at frame end, or immediately when nothing is being scanned.
        transfer  = frame_q || (state_q == StIdle && pending_q);
        shadow_d  = accept ? load_data_i : shadow_q;
        active_d  = transfer ? shadow_q : active_q;
        pending_d = transfer ? 1'b0 : (accept ? 1'b1 : pending_q);

        state_d   = state_q;
        idx_d     = idx_q;
        tmr_load  = 1'b0;
        tmr_clear = 1'b0;
        if (!enable_i) begin
            state_d   = StIdle;
            idx_d     = '0;
            tmr_clear = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d  = FirstState;
                    idx_d    = '0;
                    tmr_load = 1'b1;
                end
                StBlank: begin
                    if (blank_end) state_d = StShow;
                end
                StShow: begin
                    if (slot_end) begin
                        idx_d    = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
                        state_d  = FirstState;
                        tmr_load = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        en_d = '0;
        if (state_d == StShow) en_d[idx_d] = 1'b1;
        code_d  = (state_d == StIdle) ? '0 : active_d[idx_d];
        frame_d = (state_d == StShow) && (idx_d == LastIdx) && slot_end_next;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            ready_q   <= 1'b1;
            frame_q   <= 1'b0;
            en_q      <= '0;
            code_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            ready_q   <= !pending_d;
            frame_q   <= frame_d;
            en_q      <= en_d;
            code_q    <= code_d;
        end
    end

    assign load_ready_o = ready_q;
    assign code_out_o   = code_q;
    assign digit_en_o   = en_q;
    assign digit_idx_o  = idx_q;
    assign frame_done_o = frame_q;

endmodule
